df_tile_iterator: RTL and testbench

- Tile-loop sequencer for the dataflow controller. Accepts one layer's tile limits and per-dimension strides, then walks the tile nest (k outer, y, x, c inner).
- For each tile it emits the psums, ifmaps and weights offsets, plus reduction first/last flags, over a valid/ready handshake.
- Downstream consumer is the DMA/feeder sequencing logic; upstream is the controller register file.

---
 rtl/df_tile_iterator.sv | 258 +++++++++++++++++++++++++
 tb/tb_df_tile_iterator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/df_tile_iterator.sv
// Tile-loop sequencer: walks k/y/x/c tile nest (c innermost) and emits
// psums/ifmaps/weights offsets with reduction flags over valid/ready.
module df_tile_iterator #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 12
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [IDX_W-1:0]  i_x_lim,
  input  logic [IDX_W-1:0]  i_y_lim,
  input  logic [IDX_W-1:0]  i_k_lim,
  input  logic [IDX_W-1:0]  i_c_lim,
  input  logic [11:0]       i_ps_x_step,
  input  logic [23:0]       i_ps_y_step,
  input  logic [23:0]       i_ps_k_step,
  input  logic [11:0]       i_if_x_step,
  input  logic [23:0]       i_if_y_step,
  input  logic [23:0]       i_if_c_step,
  input  logic [11:0]       i_wt_k_step,
  input  logic [23:0]       i_wt_c_step,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_tile_valid,
  input  logic              i_tile_ready,
  output logic [ADDR_W-1:0] o_ps_offs,
  output logic [ADDR_W-1:0] o_if_offs,
  output logic [ADDR_W-1:0] o_wt_offs,
  output logic              o_first_c,
  output logic              o_last_c,
  output logic              o_last_tile
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ACC_ZERO = {ADDR_W{1'b0}};

  state_t state_q, state_d;

  logic [IDX_W-1:0]  x_lim_q, x_lim_d, y_lim_q, y_lim_d;
  logic [IDX_W-1:0]  k_lim_q, k_lim_d, c_lim_q, c_lim_d;
  logic [ADDR_W-1:0] ps_x_step_q, ps_x_step_d, ps_y_step_q, ps_y_step_d;
  logic [ADDR_W-1:0] ps_k_step_q, ps_k_step_d, if_x_step_q, if_x_step_d;
  logic [ADDR_W-1:0] if_y_step_q, if_y_step_d, if_c_step_q, if_c_step_d;
  logic [ADDR_W-1:0] wt_k_step_q, wt_k_step_d, wt_c_step_q, wt_c_step_d;

  logic [IDX_W-1:0]  x_q, x_d, y_q, y_d, k_q, k_d, c_q, c_d;

  // One accumulator per (tensor, dimension) holding index*step
  logic [ADDR_W-1:0] acc_ps_x_q, acc_ps_x_d, acc_ps_y_q, acc_ps_y_d;
  logic [ADDR_W-1:0] acc_ps_k_q, acc_ps_k_d, acc_if_x_q, acc_if_x_d;
  logic [ADDR_W-1:0] acc_if_y_q, acc_if_y_d, acc_if_c_q, acc_if_c_d;
  logic [ADDR_W-1:0] acc_wt_k_q, acc_wt_k_d, acc_wt_c_q, acc_wt_c_d;

  logic c_at_lim_s, x_at_lim_s, y_at_lim_s, k_at_lim_s;
  logic last_tile_s, handshake_s;

  assign c_at_lim_s  = (c_q == c_lim_q);
  assign x_at_lim_s  = (x_q == x_lim_q);
  assign y_at_lim_s  = (y_q == y_lim_q);
  assign k_at_lim_s  = (k_q == k_lim_q);
  assign last_tile_s = c_at_lim_s && x_at_lim_s && y_at_lim_s && k_at_lim_s;
  assign handshake_s = (state_q == ST_RUN) && i_tile_ready;

  // Next-state, configuration latch and loop-nest advance
  always_comb begin
    state_d     = state_q;
    x_lim_d     = x_lim_q;
    y_lim_d     = y_lim_q;
    k_lim_d     = k_lim_q;
    c_lim_d     = c_lim_q;
    ps_x_step_d = ps_x_step_q;
    ps_y_step_d = ps_y_step_q;
    ps_k_step_d = ps_k_step_q;
    if_x_step_d = if_x_step_q;
    if_y_step_d = if_y_step_q;
    if_c_step_d = if_c_step_q;
    wt_k_step_d = wt_k_step_q;
    wt_c_step_d = wt_c_step_q;
    x_d         = x_q;
    y_d         = y_q;
    k_d         = k_q;
    c_d         = c_q;
    acc_ps_x_d  = acc_ps_x_q;
    acc_ps_y_d  = acc_ps_y_q;
    acc_ps_k_d  = acc_ps_k_q;
    acc_if_x_d  = acc_if_x_q;
    acc_if_y_d  = acc_if_y_q;
    acc_if_c_d  = acc_if_c_q;
    acc_wt_k_d  = acc_wt_k_q;
    acc_wt_c_d  = acc_wt_c_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d     = ST_RUN;
          x_lim_d     = i_x_lim;
          y_lim_d     = i_y_lim;
          k_lim_d     = i_k_lim;
          c_lim_d     = i_c_lim;
          ps_x_step_d = ADDR_W'(i_ps_x_step);
          ps_y_step_d = ADDR_W'(i_ps_y_step);
          ps_k_step_d = ADDR_W'(i_ps_k_step);
          if_x_step_d = ADDR_W'(i_if_x_step);
          if_y_step_d = ADDR_W'(i_if_y_step);
          if_c_step_d = ADDR_W'(i_if_c_step);
          wt_k_step_d = ADDR_W'(i_wt_k_step);
          wt_c_step_d = ADDR_W'(i_wt_c_step);
          x_d         = IDX_ZERO;
          y_d         = IDX_ZERO;
          k_d         = IDX_ZERO;
          c_d         = IDX_ZERO;
          acc_ps_x_d  = ACC_ZERO;
          acc_ps_y_d  = ACC_ZERO;
          acc_ps_k_d  = ACC_ZERO;
          acc_if_x_d  = ACC_ZERO;
          acc_if_y_d  = ACC_ZERO;
          acc_if_c_d  = ACC_ZERO;
          acc_wt_k_d  = ACC_ZERO;
          acc_wt_c_d  = ACC_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!handshake_s) begin
          state_d = ST_RUN;
        end else if (last_tile_s) begin
          // k is never incremented past its limit, so indices cannot overflow
          state_d = ST_DONE;
        end else if (!c_at_lim_s) begin
          c_d        = c_q + IDX_ONE;
          acc_if_c_d = acc_if_c_q + if_c_step_q;
          acc_wt_c_d = acc_wt_c_q + wt_c_step_q;
        end else begin
          c_d        = IDX_ZERO;
          acc_if_c_d = ACC_ZERO;
          acc_wt_c_d = ACC_ZERO;
          if (!x_at_lim_s) begin
            x_d        = x_q + IDX_ONE;
            acc_ps_x_d = acc_ps_x_q + ps_x_step_q;
            acc_if_x_d = acc_if_x_q + if_x_step_q;
          end else begin
            x_d        = IDX_ZERO;
            acc_ps_x_d = ACC_ZERO;
            acc_if_x_d = ACC_ZERO;
            if (!y_at_lim_s) begin
              y_d        = y_q + IDX_ONE;
              acc_ps_y_d = acc_ps_y_q + ps_y_step_q;
              acc_if_y_d = acc_if_y_q + if_y_step_q;
            end else begin
              y_d        = IDX_ZERO;
              acc_ps_y_d = ACC_ZERO;
              acc_if_y_d = ACC_ZERO;
              k_d        = k_q + IDX_ONE;
              acc_ps_k_d = acc_ps_k_q + ps_k_step_q;
              acc_wt_k_d = acc_wt_k_q + wt_k_step_q;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, configuration, index and accumulator registers
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      x_lim_q     <= IDX_ZERO;
      y_lim_q     <= IDX_ZERO;
      k_lim_q     <= IDX_ZERO;
      c_lim_q     <= IDX_ZERO;
      ps_x_step_q <= ACC_ZERO;
      ps_y_step_q <= ACC_ZERO;
      ps_k_step_q <= ACC_ZERO;
      if_x_step_q <= ACC_ZERO;
      if_y_step_q <= ACC_ZERO;
      if_c_step_q <= ACC_ZERO;
      wt_k_step_q <= ACC_ZERO;
      wt_c_step_q <= ACC_ZERO;
      x_q         <= IDX_ZERO;
      y_q         <= IDX_ZERO;
      k_q         <= IDX_ZERO;
      c_q         <= IDX_ZERO;
      acc_ps_x_q  <= ACC_ZERO;
      acc_ps_y_q  <= ACC_ZERO;
      acc_ps_k_q  <= ACC_ZERO;
      acc_if_x_q  <= ACC_ZERO;
      acc_if_y_q  <= ACC_ZERO;
      acc_if_c_q  <= ACC_ZERO;
      acc_wt_k_q  <= ACC_ZERO;
      acc_wt_c_q  <= ACC_ZERO;
    end else begin
      state_q     <= state_d;
      x_lim_q     <= x_lim_d;
      y_lim_q     <= y_lim_d;
      k_lim_q     <= k_lim_d;
      c_lim_q     <= c_lim_d;
      ps_x_step_q <= ps_x_step_d;
      ps_y_step_q <= ps_y_step_d;
      ps_k_step_q <= ps_k_step_d;
      if_x_step_q <= if_x_step_d;
      if_y_step_q <= if_y_step_d;
      if_c_step_q <= if_c_step_d;
      wt_k_step_q <= wt_k_step_d;
      wt_c_step_q <= wt_c_step_d;
      x_q         <= x_d;
      y_q         <= y_d;
      k_q         <= k_d;
      c_q         <= c_d;
      acc_ps_x_q  <= acc_ps_x_d;
      acc_ps_y_q  <= acc_ps_y_d;
      acc_ps_k_q  <= acc_ps_k_d;
      acc_if_x_q  <= acc_if_x_d;
      acc_if_y_q  <= acc_if_y_d;
      acc_if_c_q  <= acc_if_c_d;
      acc_wt_k_q  <= acc_wt_k_d;
      acc_wt_c_q  <= acc_wt_c_d;
    end
  end

  // Descriptor outputs are forced to zero whenever no tile is presented
  always_comb begin
    o_busy       = (state_q != ST_IDLE);
    o_done       = (state_q == ST_DONE);
    o_tile_valid = 1'b0;
    o_ps_offs    = ACC_ZERO;
    o_if_offs    = ACC_ZERO;
    o_wt_offs    = ACC_ZERO;
    o_first_c    = 1'b0;
    o_last_c     = 1'b0;
    o_last_tile  = 1'b0;
    if (state_q == ST_RUN) begin
      o_tile_valid = 1'b1;
      o_ps_offs    = acc_ps_x_q + acc_ps_y_q + acc_ps_k_q;
      o_if_offs    = acc_if_x_q + acc_if_y_q + acc_if_c_q;
      o_wt_offs    = acc_wt_k_q + acc_wt_c_q;
      o_first_c    = (c_q == IDX_ZERO);
      o_last_c     = c_at_lim_s;
      o_last_tile  = last_tile_s;
    end else begin
      o_tile_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_df_tile_iterator.sv
// Scoreboard bench for df_tile_iterator: a multiplier-based model pushes the
// expected descriptors, which are popped and compared on each handshake.
module tb_df_tile_iterator;

  typedef struct packed {
    logic [31:0] ps;
    logic [31:0] ifm;
    logic [31:0] wt;
    logic        fc;
    logic        lc;
    logic        lt;
  } desc_t;

  logic        clk;
  logic        i_rstn, i_start, i_tile_ready;
  logic [11:0] i_x_lim, i_y_lim, i_k_lim, i_c_lim;
  logic [11:0] i_ps_x_step, i_if_x_step, i_wt_k_step;
  logic [23:0] i_ps_y_step, i_ps_k_step, i_if_y_step, i_if_c_step, i_wt_c_step;

  logic        o_busy, o_done, o_tile_valid, o_first_c, o_last_c, o_last_tile;
  logic [31:0] o_ps_offs, o_if_offs, o_wt_offs;
  logic        n_busy, n_done, n_tile_valid, n_first_c, n_last_c, n_last_tile;
  logic [23:0] n_ps_offs, n_if_offs, n_wt_offs;

  int    tests_run = 0;
  int    n_fail    = 0;
  desc_t exp_q[$];

  df_tile_iterator #(.ADDR_W(32), .IDX_W(12)) dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_start(i_start),
    .i_x_lim(i_x_lim), .i_y_lim(i_y_lim), .i_k_lim(i_k_lim), .i_c_lim(i_c_lim),
    .i_ps_x_step(i_ps_x_step), .i_ps_y_step(i_ps_y_step), .i_ps_k_step(i_ps_k_step),
    .i_if_x_step(i_if_x_step), .i_if_y_step(i_if_y_step), .i_if_c_step(i_if_c_step),
    .i_wt_k_step(i_wt_k_step), .i_wt_c_step(i_wt_c_step),
    .o_busy(o_busy), .o_done(o_done), .o_tile_valid(o_tile_valid),
    .i_tile_ready(i_tile_ready),
    .o_ps_offs(o_ps_offs), .o_if_offs(o_if_offs), .o_wt_offs(o_wt_offs),
    .o_first_c(o_first_c), .o_last_c(o_last_c), .o_last_tile(o_last_tile)
  );

  // Narrow-address instance sharing all inputs, to exercise modulo wrap
  df_tile_iterator #(.ADDR_W(24), .IDX_W(12)) dut24 (
    .i_clk(clk), .i_rstn(i_rstn), .i_start(i_start),
    .i_x_lim(i_x_lim), .i_y_lim(i_y_lim), .i_k_lim(i_k_lim), .i_c_lim(i_c_lim),
    .i_ps_x_step(i_ps_x_step), .i_ps_y_step(i_ps_y_step), .i_ps_k_step(i_ps_k_step),
    .i_if_x_step(i_if_x_step), .i_if_y_step(i_if_y_step), .i_if_c_step(i_if_c_step),
    .i_wt_k_step(i_wt_k_step), .i_wt_c_step(i_wt_c_step),
    .o_busy(n_busy), .o_done(n_done), .o_tile_valid(n_tile_valid),
    .i_tile_ready(i_tile_ready),
    .o_ps_offs(n_ps_offs), .o_if_offs(n_if_offs), .o_wt_offs(n_wt_offs),
    .o_first_c(n_first_c), .o_last_c(n_last_c), .o_last_tile(n_last_tile)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic desc_t observed();
    desc_t d;
    d.ps = o_ps_offs; d.ifm = o_if_offs; d.wt = o_wt_offs;
    d.fc = o_first_c; d.lc = o_last_c; d.lt = o_last_tile;
    return d;
  endfunction

  task automatic set_cfg(input logic [11:0] kl, yl, xl, cl,
                         input logic [11:0] psx, input logic [23:0] psy, psk,
                         input logic [11:0] ifx, input logic [23:0] ify, ifc,
                         input logic [11:0] wtk, input logic [23:0] wtc);
    i_k_lim = kl; i_y_lim = yl; i_x_lim = xl; i_c_lim = cl;
    i_ps_x_step = psx; i_ps_y_step = psy; i_ps_k_step = psk;
    i_if_x_step = ifx; i_if_y_step = ify; i_if_c_step = ifc;
    i_wt_k_step = wtk; i_wt_c_step = wtc;
  endtask

  task automatic push_model();
    for (int k = 0; k <= int'(i_k_lim); k++)
      for (int y = 0; y <= int'(i_y_lim); y++)
        for (int x = 0; x <= int'(i_x_lim); x++)
          for (int c = 0; c <= int'(i_c_lim); c++) begin
            desc_t d;
            logic [63:0] t;
            t = 64'(x) * 64'(i_ps_x_step) + 64'(y) * 64'(i_ps_y_step) + 64'(k) * 64'(i_ps_k_step);
            d.ps = t[31:0];
            t = 64'(x) * 64'(i_if_x_step) + 64'(y) * 64'(i_if_y_step) + 64'(c) * 64'(i_if_c_step);
            d.ifm = t[31:0];
            t = 64'(k) * 64'(i_wt_k_step) + 64'(c) * 64'(i_wt_c_step);
            d.wt = t[31:0];
            d.fc = (c == 0);
            d.lc = (c == int'(i_c_lim));
            d.lt = (c == int'(i_c_lim)) && (x == int'(i_x_lim)) &&
                   (y == int'(i_y_lim)) && (k == int'(i_k_lim));
            exp_q.push_back(d);
          end
  endtask

  task automatic start_layer();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0; 2: ready high plus a start glitch
  task automatic collect(input int mode, input int budget);
    desc_t obs, held, e;
    logic  stalled, done_seen;
    int    last_hs;
    stalled = 1'b0; done_seen = 1'b0; last_hs = -10; held = '0;
    for (int cyc = 0; cyc < budget && !done_seen; cyc++) begin
      i_tile_ready = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      if (mode == 2 && cyc == 2) begin
        i_start = 1'b1; i_x_lim = 12'd5; i_c_lim = 12'd7; i_if_c_step = 24'h333;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      obs = observed();
      if (cyc == 0) begin
        tests_run++;
        if (o_tile_valid !== 1'b1) begin
          n_fail++; $display("FAIL first_valid: got %b want 1", o_tile_valid);
        end
      end
      if (o_done) begin
        done_seen = 1'b1;
        tests_run++;
        if (exp_q.size() != 0 || cyc != last_hs + 1 || o_tile_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL done_timing: cyc %0d last_hs %0d left %0d valid %b want cyc %0d left 0 valid 0",
                   cyc, last_hs, exp_q.size(), o_tile_valid, last_hs + 1);
        end
      end else if (o_tile_valid) begin
        if (stalled) begin
          tests_run++;
          if (obs !== held) begin
            n_fail++; $display("FAIL stall_hold: got %h want %h", obs, held);
          end
        end
        tests_run++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL extra_tile: got %h want none", obs);
        end else begin
          e = exp_q[0];
          if (obs !== e || {n_ps_offs, n_if_offs, n_wt_offs} !== {e.ps[23:0], e.ifm[23:0], e.wt[23:0]}) begin
            n_fail++;
            $display("FAIL tile: got %h (narrow %h %h %h) want %h", obs, n_ps_offs, n_if_offs, n_wt_offs, e);
          end
          if (i_tile_ready) begin
            void'(exp_q.pop_front());
            last_hs = cyc; stalled = 1'b0;
          end else begin
            stalled = 1'b1; held = obs;
          end
        end
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    if (!done_seen) begin
      tests_run++; n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles, want done", budget);
    end
    @(negedge clk);
    tests_run++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL post_done: got done %b busy %b want 0 0", o_done, o_busy);
    end
    exp_q.delete();
  endtask

  task automatic set_six();
    set_cfg(12'd0, 12'd0, 12'd1, 12'd2, 12'h8, 24'h0, 24'h0,
            12'h10, 24'h0, 24'h100, 12'h0, 24'h40);
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    tests_run++;
    if ({o_busy, o_done, o_tile_valid, o_first_c, o_last_c, o_last_tile} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
                         {o_busy, o_done, o_tile_valid, o_first_c, o_last_c, o_last_tile});
    end
    tests_run++;
    if ({o_ps_offs, o_if_offs, o_wt_offs} !== 96'h0) begin
      n_fail++; $display("FAIL reset_offs: got %h %h %h want 0", o_ps_offs, o_if_offs, o_wt_offs);
    end
    @(posedge clk); #1;
    i_rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    set_cfg(12'd0, 12'd0, 12'd0, 12'd0, 12'h3, 24'h5, 24'h7,
            12'h9, 24'hb, 24'hd, 12'hf, 24'h11);
    push_model();
    start_layer();
    collect(0, 10);
  endtask

  task automatic test_six_tiles();
    set_six(); push_model(); start_layer(); collect(0, 20);
  endtask

  task automatic test_stall();
    set_six(); push_model(); start_layer(); collect(1, 40);
  endtask

  task automatic test_start_ignored();
    set_six(); push_model(); start_layer(); collect(2, 20);
  endtask

  task automatic test_wrap();
    set_cfg(12'd1, 12'd1, 12'd0, 12'd0, 12'h0, 24'h1, 24'hFFFFFF,
            12'h0, 24'h0, 24'h0, 12'h4, 24'h0);
    push_model(); start_layer(); collect(0, 20);
  endtask

  task automatic test_reset_mid();
    desc_t e;
    set_six(); push_model();
    e = exp_q[2];
    i_tile_ready = 1'b1;
    start_layer();
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    tests_run++;
    if (o_tile_valid !== 1'b1 || observed() !== e) begin
      n_fail++; $display("FAIL mid_tile3: got v%b %h want v1 %h", o_tile_valid, observed(), e);
    end
    i_rstn = 1'b0;
    @(posedge clk); #1;
    i_rstn = 1'b1;
    @(negedge clk);
    tests_run++;
    if (o_tile_valid !== 1'b0 || o_busy !== 1'b0 || {o_ps_offs, o_if_offs, o_wt_offs} !== 96'h0) begin
      n_fail++; $display("FAIL mid_abort: got v%b b%b %h %h %h want v0 b0 0 0 0",
                         o_tile_valid, o_busy, o_ps_offs, o_if_offs, o_wt_offs);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if (o_done !== 1'b0 || o_tile_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_no_done: got done %b valid %b want 0 0", o_done, o_tile_valid);
      end
    end
    @(posedge clk); #1;
    exp_q.delete();
    push_model(); start_layer(); collect(0, 20);
  endtask

  task automatic test_max_limit();
    set_cfg(12'd0, 12'd0, 12'd1, 12'hFFF, 12'h21, 24'h0, 24'h0,
            12'h7, 24'h0, 24'h10, 12'h0, 24'h3);
    push_model(); start_layer(); collect(0, 9000);
  endtask

  task automatic test_back_to_back();
    set_six(); push_model(); start_layer(); collect(0, 20);
    set_cfg(12'd1, 12'd1, 12'd1, 12'd1, 12'h5, 24'h50, 24'h500,
            12'h6, 24'h60, 24'h600, 12'h7, 24'h70);
    push_model(); start_layer(); collect(1, 80);
  endtask

  initial begin
    i_rstn = 1'b0; i_start = 1'b0; i_tile_ready = 1'b1;
    set_cfg(12'd0, 12'd0, 12'd0, 12'd0, 12'h0, 24'h0, 24'h0,
            12'h0, 24'h0, 24'h0, 12'h0, 24'h0);
    test_reset();
    test_single();
    test_six_tiles();
    test_stall();
    test_start_ignored();
    test_wrap();
    test_reset_mid();
    test_max_limit();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
    $finish;
  end

endmodule
